// File: rtl/video_timing_gen_pkg.sv
// Timing descriptors for the raster timing generator: the named formats and
// a lookup from format name to timing record.
package video_timing_pkg;

    typedef struct packed {
        logic [15:0] h_act;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_act;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
    } timing_t;

    localparam timing_t T_1080P60 = '{
        h_act: 16'd1920, h_fp: 16'd88,  h_sync: 16'd44, h_bp: 16'd148,
        v_act: 16'd1080, v_fp: 16'd4,   v_sync: 16'd5,  v_bp: 16'd36
    };

    localparam timing_t T_720P60 = '{
        h_act: 16'd1280, h_fp: 16'd110, h_sync: 16'd40, h_bp: 16'd220,
        v_act: 16'd720,  v_fp: 16'd5,   v_sync: 16'd5,  v_bp: 16'd20
    };

    // All-zero record doubles as the "unknown format" marker.
    localparam timing_t T_NONE = '0;

    function automatic timing_t fmt2timing(input string fmt);
        timing_t t;
        t = T_NONE;
        if (fmt == "1080P@60") begin
            t = T_1080P60;
        end else if (fmt == "720P@60") begin
            t = T_720P60;
        end
        return t;
    endfunction

    function automatic int unsigned h_total(input timing_t t);
        return int'(t.h_act) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
    endfunction

    function automatic int unsigned v_total(input timing_t t);
        return int'(t.v_act) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Sync stream bundle between the timing generator and the read-port ex-sync input.
// Optional hpos/vpos members exist only when VIDEO_TIMING_GEN_POS_EN is defined.
interface video_timing_gen_if;

    logic        enable;
    logic        vsync;
    logic        hsync;
    logic        de;
    logic        frame_start;
    logic [15:0] vactive;
    logic [15:0] hactive;
`ifdef VIDEO_TIMING_GEN_POS_EN
    logic [15:0] hpos;
    logic [15:0] vpos;

    modport master (
        input  enable,
        output vsync, hsync, de, frame_start, vactive, hactive, hpos, vpos
    );

    modport slave (
        output enable,
        input  vsync, hsync, de, frame_start, vactive, hactive, hpos, vpos
    );
`else
    modport master (
        input  enable,
        output vsync, hsync, de, frame_start, vactive, hactive
    );

    modport slave (
        output enable,
        input  vsync, hsync, de, frame_start, vactive, hactive
    );
`endif

endinterface

// File: rtl/video_timing_gen_axis_cnt.sv
// Wrapping 0..tot-1 counter for one raster axis; wrap flags the last count
// of an incrementing cycle so the next axis can step on it.
module vtg_axis_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    input  logic        clr,
    input  logic [15:0] tot,
    output logic [15:0] cnt,
    output logic        wrap
);

    assign wrap = inc && (cnt == (tot - 16'd1));

    // clr wins over inc so a disabled raster parks at 0 immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster timing generator feeding the read-port ex-sync input.
// Define VIDEO_TIMING_GEN_POS_EN to add registered hpos/vpos outputs.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter string       VIDEO_FORMAT = "1080P@60",
    parameter int unsigned H_ACT        = 1920,
    parameter int unsigned H_FP         = 88,
    parameter int unsigned H_SYNC       = 44,
    parameter int unsigned H_BP         = 148,
    parameter int unsigned V_ACT        = 1080,
    parameter int unsigned V_FP         = 4,
    parameter int unsigned V_SYNC       = 5,
    parameter int unsigned V_BP         = 36,
    parameter bit          HS_POL       = 1'b1,
    parameter bit          VS_POL       = 1'b1
) (
    input  logic               pclk,
    input  logic               prst_n,
    video_timing_gen_if.master vt
);

    localparam bit IS_CUSTOM = (VIDEO_FORMAT == "CUSTOM");
    localparam bit FMT_OK    = IS_CUSTOM || (VIDEO_FORMAT == "1080P@60") ||
                               (VIDEO_FORMAT == "720P@60");

    localparam timing_t T_CUSTOM = '{
        h_act: 16'(H_ACT), h_fp: 16'(H_FP), h_sync: 16'(H_SYNC), h_bp: 16'(H_BP),
        v_act: 16'(V_ACT), v_fp: 16'(V_FP), v_sync: 16'(V_SYNC), v_bp: 16'(V_BP)
    };

    localparam timing_t T_SEL = IS_CUSTOM ? T_CUSTOM : fmt2timing(VIDEO_FORMAT);

    localparam int unsigned H_TOT_I = h_total(T_SEL);
    localparam int unsigned V_TOT_I = v_total(T_SEL);

    localparam logic [15:0] H_TOT  = 16'(H_TOT_I);
    localparam logic [15:0] V_TOT  = 16'(V_TOT_I);
    localparam logic [15:0] HS_BEG = T_SEL.h_act + T_SEL.h_fp;
    localparam logic [15:0] HS_END = HS_BEG + T_SEL.h_sync;
    localparam logic [15:0] VS_BEG = T_SEL.v_act + T_SEL.v_fp;
    localparam logic [15:0] VS_END = VS_BEG + T_SEL.v_sync;

    if (!FMT_OK) begin : g_bad_format
        $fatal(1, "video_timing_gen: unknown VIDEO_FORMAT \"%s\"", VIDEO_FORMAT);
    end

    if (IS_CUSTOM && (H_ACT == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
                      V_ACT == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0))
    begin : g_bad_custom
        $fatal(1, "video_timing_gen: CUSTOM timing field is zero");
    end

    if (T_SEL.h_act == 16'd0 || T_SEL.h_fp == 16'd0 || T_SEL.h_sync == 16'd0 ||
        T_SEL.h_bp == 16'd0 || T_SEL.v_act == 16'd0 || T_SEL.v_fp == 16'd0 ||
        T_SEL.v_sync == 16'd0 || T_SEL.v_bp == 16'd0) begin : g_bad_timing
        $fatal(1, "video_timing_gen: timing field is zero or out of 16-bit range");
    end

    if (H_TOT_I > 32'd65535 || V_TOT_I > 32'd65535) begin : g_bad_total
        $fatal(1, "video_timing_gen: line or frame total exceeds 16 bits");
    end

    logic [15:0] hcnt;
    logic [15:0] vcnt;
    logic        h_wrap;
    logic        v_wrap_unused;
    logic        de_c;
    logic        hs_c;
    logic        vs_c;
    logic        fs_c;

    vtg_axis_cnt u_hcnt (
        .clk   (pclk),
        .rst_n (prst_n),
        .inc   (vt.enable),
        .clr   (~vt.enable),
        .tot   (H_TOT),
        .cnt   (hcnt),
        .wrap  (h_wrap)
    );

    vtg_axis_cnt u_vcnt (
        .clk   (pclk),
        .rst_n (prst_n),
        .inc   (vt.enable & h_wrap),
        .clr   (~vt.enable),
        .tot   (V_TOT),
        .cnt   (vcnt),
        .wrap  (v_wrap_unused)
    );

    assign de_c = (hcnt < T_SEL.h_act) && (vcnt < T_SEL.v_act);
    assign hs_c = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vs_c = (vcnt >= VS_BEG) && (vcnt < VS_END);
    assign fs_c = (hcnt == 16'd0) && (vcnt == 16'd0);

    assign vt.vactive = T_SEL.v_act;
    assign vt.hactive = T_SEL.h_act;

    // Dropping enable idles the outputs on the very next edge, same as reset.
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            vt.de          <= 1'b0;
            vt.frame_start <= 1'b0;
            vt.hsync       <= ~HS_POL;
            vt.vsync       <= ~VS_POL;
        end else if (!vt.enable) begin
            vt.de          <= 1'b0;
            vt.frame_start <= 1'b0;
            vt.hsync       <= ~HS_POL;
            vt.vsync       <= ~VS_POL;
        end else begin
            vt.de          <= de_c;
            vt.frame_start <= fs_c;
            vt.hsync       <= hs_c ? HS_POL : ~HS_POL;
            vt.vsync       <= vs_c ? VS_POL : ~VS_POL;
        end
    end

`ifdef VIDEO_TIMING_GEN_POS_EN
    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            vt.hpos <= '0;
            vt.vpos <= '0;
        end else if (!vt.enable) begin
            vt.hpos <= '0;
            vt.vpos <= '0;
        end else begin
            vt.hpos <= hcnt;
            vt.vpos <= vcnt;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench: CUSTOM 8/2/2/2 x 4/1/1/1 raster checked against a scoreboard,
// plus a 1080P@60 instance for line-level timing.
module tb_video_timing_gen;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } obs_t;

    localparam obs_t IDLE = 4'b0010;

    logic pclk = 1'b0;
    logic prst_n;

    always #5 pclk = ~pclk;

    video_timing_gen_if vt();
    video_timing_gen_if vt2();

    video_timing_gen #(
        .VIDEO_FORMAT ("CUSTOM"),
        .H_ACT  (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
        .V_ACT  (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .HS_POL (1'b1),
        .VS_POL (1'b0)
    ) dut (
        .pclk   (pclk),
        .prst_n (prst_n),
        .vt     (vt)
    );

    video_timing_gen #(
        .VIDEO_FORMAT ("1080P@60")
    ) dut_1080 (
        .pclk   (pclk),
        .prst_n (prst_n),
        .vt     (vt2)
    );

    int   checks   = 0;
    int   failures = 0;
    obs_t exp_q[$];
    obs_t hist[0:511];
    int   mh, mv, cyc, hist_base;
    bit   hist_on;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic obs_t sample();
        return {vt.de, vt.hsync, vt.vsync, vt.frame_start};
    endfunction

    // Drive one cycle of enable, push the expected registered outputs for the
    // raster position this cycle occupies, then compare after the edge.
    task automatic cycle(input logic en);
        obs_t e;
        vt.enable = en;
        if (en) begin
            e.de = (mh < 8) && (mv < 4);
            e.hs = (mh >= 10) && (mh < 12);
            e.vs = (mv != 5);
            e.fs = (mh == 0) && (mv == 0);
            mh++;
            if (mh == 14) begin
                mh = 0;
                mv = (mv == 6) ? 0 : mv + 1;
            end
        end else begin
            e  = IDLE;
            mh = 0;
            mv = 0;
        end
        exp_q.push_back(e);
        @(posedge pclk);
        #1;
        cyc++;
        if (hist_on && (cyc - hist_base) < 512) hist[cyc - hist_base] = sample();
        chk("raster", 32'(sample()), 32'(exp_q.pop_front()));
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        int fs_at[$];
        int n_de, n_vs_lo, first_vs_lo, guard;
        int n, hi, lo, n_hs, hpos_bad;

        prst_n     = 1'b0;
        vt.enable  = 1'b0;
        vt2.enable = 1'b0;
        mh = 0; mv = 0; cyc = 0; hist_on = 1'b0; hist_base = 0;

        // 1: reset state and constants
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_outputs", 32'(sample()), 32'(IDLE));
        chk("rst_vactive", 32'(vt.vactive), 32'd4);
        chk("rst_hactive", 32'(vt.hactive), 32'd8);
        chk("rst_1080_hactive", 32'(vt2.hactive), 32'd1920);
        chk("rst_1080_vactive", 32'(vt2.vactive), 32'd1080);
`ifdef VIDEO_TIMING_GEN_POS_EN
        chk("rst_hpos", 32'(vt.hpos), 32'd0);
`endif
        @(negedge pclk);
        prst_n = 1'b1;
        tick();
        repeat (3) cycle(1'b0);

        // 2 and 3: enable at cycle N (offset 0), run three frames and a bit
        hist_base = cyc;
        hist_on   = 1'b1;
        repeat (3 * 98 + 8) cycle(1'b1);
        hist_on   = 1'b0;

        for (int o = 1; o <= 302; o++) if (hist[o].fs) fs_at.push_back(o);
        chk("fs_count", 32'(fs_at.size()), 32'd4);
        chk("fs_first", 32'(fs_at[0]), 32'd1);
        chk("frame_period_1", 32'(fs_at[1] - fs_at[0]), 32'd98);
        chk("frame_period_2", 32'(fs_at[2] - fs_at[1]), 32'd98);

        n_de = 0;
        for (int o = 1; o <= 8; o++) if (hist[o].de) n_de++;
        chk("de_first_line", 32'(n_de), 32'd8);
        chk("de_off_at_9", 32'(hist[9].de), 32'd0);
        chk("hsync_window", 32'({hist[10].hs, hist[11].hs, hist[12].hs, hist[13].hs}), 32'b0110);

        n_de = 0; n_vs_lo = 0; first_vs_lo = -1;
        for (int o = 1; o < 99; o++) begin
            if (hist[o].de) n_de++;
            if (!hist[o].vs) begin
                n_vs_lo++;
                if (first_vs_lo < 0) first_vs_lo = o;
            end
        end
        chk("de_per_frame", 32'(n_de), 32'd32);
        chk("vsync_low_len", 32'(n_vs_lo), 32'd14);
        chk("vsync_offset", 32'(first_vs_lo - fs_at[0]), 32'd70);

        // 4: drop enable when the counters sit at line 2, pixel 3
        guard = 0;
        while (!(mh == 3 && mv == 2) && guard < 200) begin
            cycle(1'b1);
            guard++;
        end
        chk("pre_drop_de", 32'(vt.de), 32'd1);
        cycle(1'b0);
        chk("drop_de", 32'(vt.de), 32'd0);
        chk("drop_hsync", 32'(vt.hsync), 32'd0);
        cycle(1'b0);
        cycle(1'b1);
        chk("reen_fs", 32'(vt.frame_start), 32'd1);
        cycle(1'b1);
        chk("reen_fs_single", 32'(vt.frame_start), 32'd0);

        // 5: asynchronous reset mid-line while de is high
        guard = 0;
        while (mh != 5 && guard < 200) begin
            cycle(1'b1);
            guard++;
        end
        chk("pre_rst_de", 32'(vt.de), 32'd1);
        #2;
        prst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 32'(sample()), 32'(IDLE));
        chk("async_rst_vactive", 32'(vt.vactive), 32'd4);
        mh = 0; mv = 0;
        vt.enable = 1'b0;
        @(negedge pclk);
        prst_n = 1'b1;
        tick();
        cycle(1'b1);
        chk("post_rst_fs", 32'(vt.frame_start), 32'd1);
        vt.enable = 1'b0;

        // 6: 1080P@60 line timing
        vt2.enable = 1'b1;
        n = 0;
        while (!vt2.de && n < 10) begin
            tick();
            n++;
        end
        chk("1080_de_latency", 32'(n), 32'd1);
        hi = 0; hpos_bad = 0;
        while (vt2.de && hi < 3000) begin
`ifdef VIDEO_TIMING_GEN_POS_EN
            if (vt2.hpos !== 16'(hi)) hpos_bad++;
`endif
            tick();
            hi++;
        end
        chk("1080_de_per_line", 32'(hi), 32'd1920);
        lo = 0; n_hs = 0;
        while (!vt2.de && lo < 3000) begin
            if (vt2.hsync) n_hs++;
            tick();
            lo++;
        end
        chk("1080_line_period", 32'(hi + lo), 32'd2200);
        chk("1080_hsync_width", 32'(n_hs), 32'd44);
`ifdef VIDEO_TIMING_GEN_POS_EN
        chk("1080_hpos_seq", 32'(hpos_bad), 32'd0);
        chk("1080_vpos_line1", 32'(vt2.vpos), 32'd1);
`endif
        vt2.enable = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
